// File: rtl/bus_device_endpoint_if.sv
// Device side of the broadcast bus handshake: TX head (pndng/D_pop/pop) and
// RX delivery (push/D_push).
interface bus_device_endpoint_if #(
  parameter int width = 16
);
  logic             pndng;
  logic [width-1:0] D_pop;
  logic             pop;
  logic             push;
  logic [width-1:0] D_push;

  modport master (input pndng, input D_pop, output pop, output push, output D_push);
  modport slave  (output pndng, output D_pop, input pop, input push, input D_push);
endinterface

// File: rtl/bus_device_endpoint.sv
// Bus device endpoint: local TX FIFO presented to the bus and an
// address-filtered RX FIFO fed by the bus, both first-word fall-through.
module bus_device_endpoint #(
  parameter int             width     = 16,
  parameter int             depth     = 8,
  parameter logic [7:0]     id        = 8'h00,
  parameter logic [7:0]     broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [width-1:0]           wr_data,
  output logic                       tx_full,
  bus_device_endpoint_if.slave       bus,
  input  logic                       rd_en,
  output logic [width-1:0]           rd_data,
  output logic                       rx_empty,
  output logic [$clog2(depth):0]     rx_count,
  output logic [7:0]                 misdir_cnt,
  output logic                       tx_ovf,
  output logic                       tx_unf,
  output logic                       rx_ovf
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = c;
    if (inc && !dec) r = c + CW'(1);
    if (dec && !inc) r = c - CW'(1);
    return r;
  endfunction

  logic [width-1:0] tx_mem [depth];
  logic [width-1:0] rx_mem [depth];
  logic [AW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]    tx_cnt, rx_cnt;

  logic tx_nonempty, rx_nonempty, rx_full;
  logic tx_wr_ok, tx_pop_ok, rx_match, rx_wr_ok, rx_rd_ok;

  assign tx_nonempty = (tx_cnt != '0);
  assign rx_nonempty = (rx_cnt != '0);
  assign tx_full     = (tx_cnt == FULL_CNT);
  assign rx_full     = (rx_cnt == FULL_CNT);

  // A full FIFO is never empty, so a same-cycle pop/read always frees the slot being written.
  assign tx_pop_ok = bus.pop && tx_nonempty;
  assign tx_wr_ok  = wr_en && (!tx_full || bus.pop);
  assign rx_match  = (bus.D_push[width-1 -: 8] == id) || (bus.D_push[width-1 -: 8] == broadcast);
  assign rx_rd_ok  = rd_en && rx_nonempty;
  assign rx_wr_ok  = bus.push && rx_match && (!rx_full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_cnt     <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      misdir_cnt <= '0;
      tx_ovf     <= 1'b0;
      tx_unf     <= 1'b0;
      rx_ovf     <= 1'b0;
    end else begin
      if (tx_wr_ok)  tx_wp <= tx_wp + AW'(1);
      if (tx_pop_ok) tx_rp <= tx_rp + AW'(1);
      tx_cnt <= next_cnt(tx_cnt, tx_wr_ok, tx_pop_ok);
      if (rx_wr_ok)  rx_wp <= rx_wp + AW'(1);
      if (rx_rd_ok)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= next_cnt(rx_cnt, rx_wr_ok, rx_rd_ok);
      if (bus.push && !rx_match)               misdir_cnt <= sat_inc8(misdir_cnt);
      if (wr_en && tx_full && !bus.pop)        tx_ovf     <= 1'b1;
      if (bus.pop && !tx_nonempty)             tx_unf     <= 1'b1;
      if (bus.push && rx_match && rx_full && !rd_en) rx_ovf <= 1'b1;
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem[tx_wp] <= wr_data;
    if (rx_wr_ok) rx_mem[rx_wp] <= bus.D_push;
  end

  assign bus.pndng = tx_nonempty;
  assign bus.D_pop = tx_mem[tx_rp];
  assign rd_data   = rx_mem[rx_rp];
  assign rx_empty  = !rx_nonempty;
  assign rx_count  = rx_cnt;
endmodule

// File: tb/tb_bus_device_endpoint.sv
// Directed self-checking bench for bus_device_endpoint (width 16, depth 8, id 2).
module tb_bus_device_endpoint;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        tx_full;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rx_empty;
  logic [3:0]  rx_count;
  logic [7:0]  misdir_cnt;
  logic        tx_ovf, tx_unf, rx_ovf;
  int checks = 0;
  int errors = 0;

  bus_device_endpoint_if #(.width(16)) bus ();

  bus_device_endpoint #(.width(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .bus(bus), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .misdir_cnt(misdir_cnt), .tx_ovf(tx_ovf), .tx_unf(tx_unf),
    .rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] d);
    bus.push = 1'b1; bus.D_push = d;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.pop = 1'b0; bus.push = 1'b0; bus.D_push = '0;
    apply_reset();
    checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng got %b want 0", bus.pndng); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got %b want 1", rx_empty); end
    checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
    checks++; if (misdir_cnt !== 8'd0) begin errors++; $display("FAIL reset_misdir got %0d want 0", misdir_cnt); end
    checks++; if ({tx_ovf, tx_unf, rx_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {tx_ovf, tx_unf, rx_ovf}); end
  endtask

  task automatic test_tx_basic();
    do_write(16'h0203);
    checks++; if (bus.pndng !== 1'b1) begin errors++; $display("FAIL txb_pndng got %b want 1", bus.pndng); end
    checks++; if (bus.D_pop !== 16'h0203) begin errors++; $display("FAIL txb_dpop got %h want 0203", bus.D_pop); end
    do_pop();
    checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL txb_pndng_after got %b want 0", bus.pndng); end
    checks++; if (tx_unf !== 1'b0) begin errors++; $display("FAIL txb_unf got %b want 0", tx_unf); end
  endtask

  task automatic test_rx_filter();
    do_push(16'h02AA);
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL rxf_first_visible got %b want 0", rx_empty); end
    do_push(16'hFF55);
    do_push(16'h0311);
    checks++; if (rx_count !== 4'd2) begin errors++; $display("FAIL rxf_count got %0d want 2", rx_count); end
    checks++; if (misdir_cnt !== 8'd1) begin errors++; $display("FAIL rxf_misdir got %0d want 1", misdir_cnt); end
    checks++; if (rd_data !== 16'h02AA) begin errors++; $display("FAIL rxf_rd0 got %h want 02AA", rd_data); end
    do_read();
    checks++; if (rd_data !== 16'hFF55) begin errors++; $display("FAIL rxf_rd1 got %h want FF55", rd_data); end
    do_read();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rxf_empty got %b want 1", rx_empty); end
    do_read();
    checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL rxf_rd_on_empty got %0d want 0", rx_count); end
  endtask

  task automatic test_tx_overflow();
    for (int i = 1; i <= 9; i++) begin
      do_write(16'h0100 + 16'(i));
      if (i == 8) begin
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL txo_full got %b want 1", tx_full); end
        checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL txo_early_ovf got %b want 0", tx_ovf); end
      end
    end
    checks++; if (tx_ovf !== 1'b1) begin errors++; $display("FAIL txo_ovf got %b want 1", tx_ovf); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.D_pop !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL txo_order[%0d] got %h want %h", i, bus.D_pop, 16'h0100 + 16'(i));
      end
      do_pop();
    end
    checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL txo_drained got %b want 0", bus.pndng); end
  endtask

  task automatic test_tx_simultaneous();
    apply_reset();
    for (int i = 0; i < 8; i++) do_write(16'h0A00 + 16'(i));
    wr_en = 1'b1; wr_data = 16'h0AFF; bus.pop = 1'b1;
    tick();
    wr_en = 1'b0; bus.pop = 1'b0;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL txs_full got %b want 1", tx_full); end
    checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL txs_ovf got %b want 0", tx_ovf); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (bus.D_pop !== 16'h0A00 + 16'(i)) begin
        errors++; $display("FAIL txs_order[%0d] got %h want %h", i, bus.D_pop, 16'h0A00 + 16'(i));
      end
      do_pop();
    end
    checks++; if (bus.D_pop !== 16'h0AFF) begin errors++; $display("FAIL txs_new_8th got %h want 0AFF", bus.D_pop); end
    do_pop();
    checks++; if (tx_unf !== 1'b0) begin errors++; $display("FAIL txs_no_unf got %b want 0", tx_unf); end
    wr_en = 1'b1; wr_data = 16'h0B0B; bus.pop = 1'b1;
    tick();
    wr_en = 1'b0; bus.pop = 1'b0;
    checks++; if (tx_unf !== 1'b1) begin errors++; $display("FAIL txs_unf got %b want 1", tx_unf); end
    checks++; if (bus.pndng !== 1'b1) begin errors++; $display("FAIL txs_retained got %b want 1", bus.pndng); end
    checks++; if (bus.D_pop !== 16'h0B0B) begin errors++; $display("FAIL txs_retained_data got %h want 0B0B", bus.D_pop); end
  endtask

  task automatic test_rx_overflow();
    apply_reset();
    for (int i = 0; i < 8; i++) do_push(16'h0200 + 16'(i));
    checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL rxo_fill got %0d want 8", rx_count); end
    do_push(16'h02EE);
    checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL rxo_ovf got %b want 1", rx_ovf); end
    checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL rxo_count got %0d want 8", rx_count); end
    apply_reset();
    for (int i = 0; i < 8; i++) do_push(16'h0200 + 16'(i));
    bus.push = 1'b1; bus.D_push = 16'hFF77; rd_en = 1'b1;
    tick();
    bus.push = 1'b0; rd_en = 1'b0;
    checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL rxs_count got %0d want 8", rx_count); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL rxs_ovf got %b want 0", rx_ovf); end
    checks++; if (rd_data !== 16'h0201) begin errors++; $display("FAIL rxs_head got %h want 0201", rd_data); end
    for (int i = 0; i < 7; i++) do_read();
    checks++; if (rd_data !== 16'hFF77) begin errors++; $display("FAIL rxs_last got %h want FF77", rd_data); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_push(16'h0500);
    do_pop();
    for (int i = 0; i < 5; i++) do_write(16'h0C00 + 16'(i));
    checks++; if ({bus.pndng, tx_unf, misdir_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL ar_pre got %b/%b/%0d want 1/1/1", bus.pndng, tx_unf, misdir_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL ar_pndng got %b want 0", bus.pndng); end
    checks++; if (tx_unf !== 1'b0) begin errors++; $display("FAIL ar_unf got %b want 0", tx_unf); end
    checks++; if (misdir_cnt !== 8'd0) begin errors++; $display("FAIL ar_misdir got %0d want 0", misdir_cnt); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ar_rx_empty got %b want 1", rx_empty); end
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1; wr_data = 16'h0777;
    tick();
    wr_en = 1'b0;
    checks++; if (bus.pndng !== 1'b1) begin errors++; $display("FAIL ar_first_wr got %b want 1", bus.pndng); end
    checks++; if (bus.D_pop !== 16'h0777) begin errors++; $display("FAIL ar_first_data got %h want 0777", bus.D_pop); end
    do_pop();
    checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL ar_discarded got %b want 0", bus.pndng); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_filter();
    test_tx_overflow();
    test_tx_simultaneous();
    test_rx_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
